// File: rtl/rv_wb_checker.sv
// rtl/rv_wb_checker.sv - writeback-snooping self-check monitor with shadow register file and expected-value table
// Optional macro WBCHK_LAST_WRITE_EN adds per-register last-write cycle stamps and the fail_cycle output.
module rv_wb_checker #(
  parameter int XLEN           = 32,
  parameter int NREGS          = 32,
  parameter int NCHK           = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16,
  localparam int RW            = $clog2(NREGS),
  localparam int IW            = (NCHK > 1) ? $clog2(NCHK) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic             wb_en,
  input  logic [RW-1:0]    wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             exp_wr,
  input  logic [IW-1:0]    exp_idx,
  input  logic [RW-1:0]    exp_reg,
  input  logic [XLEN-1:0]  exp_val,
  input  logic             exp_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [IW:0]      err_count,
  output logic [IW-1:0]    fail_idx,
  output logic [XLEN-1:0]  fail_actual,
  output logic [CNT_W-1:0] cycle_count
`ifdef WBCHK_LAST_WRITE_EN
  ,
  output logic [CNT_W-1:0] fail_cycle
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  shadow_q [NREGS];
  logic [XLEN-1:0]  shadow_d [NREGS];
  logic [RW-1:0]    tab_reg_q [NCHK];
  logic [RW-1:0]    tab_reg_d [NCHK];
  logic [XLEN-1:0]  tab_val_q [NCHK];
  logic [XLEN-1:0]  tab_val_d [NCHK];
  logic [NCHK-1:0]  tab_en_q, tab_en_d;
  logic [IW-1:0]    chk_idx_q, chk_idx_d;
  logic [IW:0]      err_q, err_d;
  logic [IW-1:0]    fail_idx_q, fail_idx_d;
  logic [XLEN-1:0]  fail_actual_q, fail_actual_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cycle_inc;
  logic [XLEN-1:0]  cur_actual;
`ifdef WBCHK_LAST_WRITE_EN
  logic [CNT_W-1:0] stamp_q [NREGS];
  logic [CNT_W-1:0] stamp_d [NREGS];
  logic [CNT_W-1:0] fail_cycle_q, fail_cycle_d;
`endif

  assign cycle_inc  = (&cycle_q) ? cycle_q : cycle_q + CNT_W'(1);
  assign cur_actual = shadow_q[tab_reg_q[chk_idx_q]];

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    tab_reg_d     = tab_reg_q;
    tab_val_d     = tab_val_q;
    tab_en_d      = tab_en_q;
    chk_idx_d     = chk_idx_q;
    err_d         = err_q;
    fail_idx_d    = fail_idx_q;
    fail_actual_d = fail_actual_q;
    cycle_d       = cycle_q;
    timeout_d     = timeout_q;
`ifdef WBCHK_LAST_WRITE_EN
    stamp_d       = stamp_q;
    fail_cycle_d  = fail_cycle_q;
`endif

    if ((state_q == S_IDLE || state_q == S_DONE) && exp_wr) begin
      tab_reg_d[exp_idx] = exp_reg;
      tab_val_d[exp_idx] = exp_val;
      tab_en_d[exp_idx]  = exp_en;
    end

    // start is honoured everywhere except CHECK; it wipes run state but keeps the table
    if (start && state_q != S_CHECK) begin
      state_d       = S_RUN;
      chk_idx_d     = '0;
      err_d         = '0;
      fail_idx_d    = '0;
      fail_actual_d = '0;
      cycle_d       = '0;
      timeout_d     = 1'b0;
      for (int i = 0; i < NREGS; i++) shadow_d[i] = '0;
`ifdef WBCHK_LAST_WRITE_EN
      fail_cycle_d  = '0;
      for (int i = 0; i < NREGS; i++) stamp_d[i] = '0;
`endif
    end else begin
      case (state_q)
        S_RUN: begin
          if (wb_en && wb_rd != '0) begin
            shadow_d[wb_rd] = wb_data;
`ifdef WBCHK_LAST_WRITE_EN
            stamp_d[wb_rd]  = cycle_q;
`endif
          end
          if (halt_req) begin
            state_d   = S_CHECK;
            chk_idx_d = '0;
            cycle_d   = cycle_inc;
          end else if (cycle_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end else begin
            cycle_d   = cycle_inc;
          end
        end
        S_CHECK: begin
          if (tab_en_q[chk_idx_q] && cur_actual != tab_val_q[chk_idx_q]) begin
            err_d = err_q + 1'b1;
            if (err_q == '0) begin
              fail_idx_d    = chk_idx_q;
              fail_actual_d = cur_actual;
`ifdef WBCHK_LAST_WRITE_EN
              fail_cycle_d  = stamp_q[tab_reg_q[chk_idx_q]];
`endif
            end
          end
          if (chk_idx_q == IW'(NCHK - 1)) state_d = S_DONE;
          else chk_idx_d = chk_idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tab_en_q      <= '0;
      chk_idx_q     <= '0;
      err_q         <= '0;
      fail_idx_q    <= '0;
      fail_actual_q <= '0;
      cycle_q       <= '0;
      timeout_q     <= 1'b0;
      for (int i = 0; i < NREGS; i++) shadow_q[i] <= '0;
      for (int i = 0; i < NCHK; i++) begin
        tab_reg_q[i] <= '0;
        tab_val_q[i] <= '0;
      end
`ifdef WBCHK_LAST_WRITE_EN
      fail_cycle_q  <= '0;
      for (int i = 0; i < NREGS; i++) stamp_q[i] <= '0;
`endif
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      tab_reg_q     <= tab_reg_d;
      tab_val_q     <= tab_val_d;
      tab_en_q      <= tab_en_d;
      chk_idx_q     <= chk_idx_d;
      err_q         <= err_d;
      fail_idx_q    <= fail_idx_d;
      fail_actual_q <= fail_actual_d;
      cycle_q       <= cycle_d;
      timeout_q     <= timeout_d;
`ifdef WBCHK_LAST_WRITE_EN
      stamp_q       <= stamp_d;
      fail_cycle_q  <= fail_cycle_d;
`endif
    end
  end

  assign busy        = (state_q == S_RUN) || (state_q == S_CHECK);
  assign done        = (state_q == S_DONE);
  assign pass        = done && (err_q == '0) && !timeout_q;
  assign timeout     = timeout_q;
  assign err_count   = err_q;
  assign fail_idx    = fail_idx_q;
  assign fail_actual = fail_actual_q;
  assign cycle_count = cycle_q;
`ifdef WBCHK_LAST_WRITE_EN
  assign fail_cycle  = fail_cycle_q;
`endif

endmodule

// File: tb/tb_rv_wb_checker.sv
// tb/tb_rv_wb_checker.sv - directed self-checking bench for rv_wb_checker (NCHK=4, TIMEOUT_CYCLES=16)
module tb_rv_wb_checker;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NCHK = 4;
  localparam int TMO = 16;
  localparam int CNT_W = 16;
  localparam int RW = 5;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0, halt_req = 1'b0, wb_en = 1'b0, exp_wr = 1'b0, exp_en = 1'b0;
  logic [RW-1:0]    wb_rd = '0, exp_reg = '0;
  logic [XLEN-1:0]  wb_data = '0, exp_val = '0;
  logic [IW-1:0]    exp_idx = '0;
  logic             busy, done, pass, timeout;
  logic [IW:0]      err_count;
  logic [IW-1:0]    fail_idx;
  logic [XLEN-1:0]  fail_actual;
  logic [CNT_W-1:0] cycle_count;
`ifdef WBCHK_LAST_WRITE_EN
  logic [CNT_W-1:0] fail_cycle;
`endif

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  rv_wb_checker #(.XLEN(XLEN), .NREGS(NREGS), .NCHK(NCHK), .TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .exp_wr(exp_wr), .exp_idx(exp_idx), .exp_reg(exp_reg), .exp_val(exp_val), .exp_en(exp_en),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
    .fail_idx(fail_idx), .fail_actual(fail_actual), .cycle_count(cycle_count)
`ifdef WBCHK_LAST_WRITE_EN
    , .fail_cycle(fail_cycle)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input int r, input logic [XLEN-1:0] v, input logic en);
    exp_wr = 1'b1; exp_idx = IW'(idx); exp_reg = RW'(r); exp_val = v; exp_en = en;
    tick();
    exp_wr = 1'b0;
  endtask

  task automatic wb(input int r, input logic [XLEN-1:0] v);
    wb_en = 1'b1; wb_rd = RW'(r); wb_data = v;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_halt();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_fidx"}, fail_idx, 0);
    check({tag, "_fact"}, fail_actual, 0);
    check({tag, "_cyc"}, cycle_count, 0);
  endtask

  initial begin
    tick(); tick();
    check_reset_values("rst");
    rst = 1'b0;
    tick();

    load(0, 1, 32'd5, 1'b1);
    load(1, 2, 32'd10, 1'b1);
    load(2, 3, 32'd15, 1'b1);
    load(3, 4, 32'd5, 1'b1);
    check("idle_busy", busy, 0);

    // all-correct program
    pulse_start();
    check("run_busy", busy, 1);
    wb(1, 32'd5); wb(2, 32'd10); wb(3, 32'd15); wb(4, 32'd5);
    pulse_halt();
    check("chk_busy", busy, 1);
    wait_done(n);
    check("t1_latency", n, NCHK);
    check("t1_pass", pass, 1);
    check("t1_err", err_count, 0);
    check("t1_cyc", cycle_count, 5);
    check("t1_busy", busy, 0);

    // single mismatch at index 2
    pulse_start();
    check("t2_cleared_done", done, 0);
    wb(1, 32'd5); wb(2, 32'd10); wb(3, 32'd14); wb(4, 32'd5);
    pulse_halt();
    wait_done(n);
    check("t2_latency", n, NCHK);
    check("t2_pass", pass, 0);
    check("t2_err", err_count, 1);
    check("t2_fidx", fail_idx, 2);
    check("t2_fact", fail_actual, 32'h0000000E);
    check("t2_timeout", timeout, 0);

`ifdef WBCHK_LAST_WRITE_EN
    pulse_start();
    wb(1, 32'd5);
    repeat (6) tick();
    wb(2, 32'd11);
    wb(3, 32'd15); wb(4, 32'd5);
    pulse_halt();
    wait_done(n);
    check("t6_err", err_count, 1);
    check("t6_fidx", fail_idx, 1);
    check("t6_fact", fail_actual, 32'd11);
    check("t6_fcycle", fail_cycle, 7);
`endif

    // watchdog, preceded by a restart in RUN
    pulse_start();
    tick(); tick(); tick();
    check("t3_cyc_pre", cycle_count, 3);
    pulse_start();
    check("t3_restart_cyc", cycle_count, 0);
    wait_done(n);
    check("t3_latency", n, TMO);
    check("t3_timeout", timeout, 1);
    check("t3_pass", pass, 0);
    check("t3_cyc", cycle_count, TMO - 1);
    check("t3_err", err_count, 0);

    // x0 writes dropped, same-cycle wb+halt, exp_wr ignored in RUN
    load(0, 0, 32'd0, 1'b1);
    load(1, 5, 32'd3, 1'b1);
    load(2, 0, 32'd0, 1'b0);
    load(3, 0, 32'd0, 1'b0);
    pulse_start();
    check("t4_timeout_clr", timeout, 0);
    wb(0, 32'hDEADBEEF);
    load(2, 6, 32'd99, 1'b1);
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'd3; halt_req = 1'b1;
    tick();
    wb_en = 1'b0; halt_req = 1'b0;
    wait_done(n);
    check("t4_latency", n, NCHK);
    check("t4_pass", pass, 1);
    check("t4_err", err_count, 0);

    // start ignored in CHECK, then reset mid-CHECK clears the table
    pulse_start();
    pulse_halt();
    pulse_start();
    check("t5_chk_busy", busy, 1);
    check("t5_chk_cyc", cycle_count, 1);
    rst = 1'b1;
    tick();
    check_reset_values("t5_rst");
    rst = 1'b0;
    tick();
    pulse_start();
    pulse_halt();
    wait_done(n);
    check("t5_latency", n, NCHK);
    check("t5_pass", pass, 1);
    check("t5_err", err_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
